fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-low (rst=0 resets).
REQ-005 SHALL have port imem_addr  out  32  instruction memory address, equal to the fetch PC.
REQ-006 SHALL have port imem_req  out  1  memory request, held with a stable imem_addr until imem_ready.
REQ-007 SHALL have port imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-008 SHALL have port imem_ready  in  1  response strobe; completes the outstanding request.
REQ-009 SHALL have port redirect  in  1  branch/jump taken: flush queue and refetch.
REQ-010 SHALL have port redirect_pc  in  32  target address, sampled when redirect=1.
REQ-011 SHALL have port ifid_write  in  1  IF/ID register accepts the head entry (0 = stall).
REQ-012 SHALL have port ins_out  out  32  head instruction to IF/ID.
REQ-013 SHALL have port pc_plus4_out  out  32  head instruction address + 4 to IF/ID.
REQ-014 SHALL have port ins_valid  out  1  head entry is valid.

Function
REQ-015 SHALL hold a circular queue of DEPTH entries {instr, pc+4} with read/write pointers and a count of 0..DEPTH.
REQ-016 SHALL use FSM states FETCH (imem_req=1), FULL (imem_req=0), DRAIN (imem_req=1, response discarded).
REQ-017 SHALL allow at most one outstanding request; a request is complete on the cycle imem_ready=1 while imem_req=1.
REQ-018 In FETCH with imem_ready=1, SHALL push {imem_rdata, fetch_pc+4} and advance fetch_pc by 4 (modulo 2^32 wrap).
REQ-019 SHALL pop the head when ins_valid=1 and ifid_write=1; simultaneous push and pop leave count unchanged.
REQ-020 SHALL go FETCH->FULL when a push, without a pop, makes count==DEPTH; FULL->FETCH on the first pop.
REQ-021 ins_valid SHALL be 1 iff count>0; ins_out/pc_plus4_out SHALL show the head entry, 0 when empty.
REQ-022 On redirect=1, SHALL clear the queue (count=0) and load fetch_pc<=redirect_pc; redirect takes priority over push and pop in that cycle.
REQ-023 Redirect in FETCH with imem_ready=0: SHALL enter DRAIN, hold the old address until imem_ready, discard that word, then FETCH at redirect_pc.
REQ-024 Redirect coincident with imem_ready=1, or in FULL: SHALL discard any response, go to FETCH, and issue redirect_pc on the next cycle.
REQ-025 Redirect during DRAIN SHALL overwrite the pending target and remain in DRAIN.
REQ-026 Without bypass, SHALL deliver an instruction no earlier than one cycle after its imem_ready.

Reset
REQ-027 While rst=0: state=FETCH, fetch_pc=RESET_PC, count=0, pointers=0, entries=0.
REQ-028 Outputs under reset: imem_addr=RESET_PC, imem_req=0, ins_out=0, pc_plus4_out=0, ins_valid=0.
REQ-029 Reset mid-request SHALL abandon the request; after release the first request is RESET_PC on the following edge.

Configuration
REQ-030 Macro FETCH_BYPASS_EN, when defined: count==0, FETCH and imem_ready=1 SHALL drive ins_out=imem_rdata and ins_valid=1 in the same cycle, and the word is not pushed if ifid_write=1.
REQ-031 Without FETCH_BYPASS_EN, SHALL use no combinational path from imem_rdata/imem_ready to the outputs.

Verification
REQ-032 Reset release, imem_ready=1 constant, ifid_write=1 -> imem_addr 0,4,8,...; ins_valid first high one cycle after the first response; pc_plus4_out=4.
REQ-033 ifid_write=0, imem_ready=1 -> after 4 pushes FULL, imem_req=0, count=4; one pop -> imem_req=1 next cycle with imem_addr=16.
REQ-034 Redirect to 32'h100 while the request at 8 is stalled (imem_ready=0) -> DRAIN; word for 8 never appears; next ins_out fetched from 0x100, pc_plus4_out=0x104.
REQ-035 Redirect coincident with imem_ready and a pop, queue at 3 -> count=0, ins_valid=0 next cycle, imem_addr=redirect_pc.
REQ-036 fetch_pc=32'hFFFFFFFC with response -> pc_plus4_out=0, next imem_addr=0.
REQ-037 With FETCH_BYPASS_EN, queue empty, imem_rdata=32'h8C220004, imem_ready=1 -> same cycle ins_valid=1, ins_out=32'h8C220004.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory
// into a DEPTH-entry circular buffer and feeds the head entry to IF/ID.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the outputs
// when the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        ifid_write,
    output logic [31:0] ins_out,
    output logic [31:0] pc_plus4_out,
    output logic        ins_valid
);

    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam int unsigned   CW   = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        FETCH,
        FULL,
        DRAIN
    } state_t;

    state_t        state, state_next;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc4_mem   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   fetch_pc, fetch_pc_next, fetch_pc_inc;
    logic [31:0]   target, target_next;
    logic          push, pop, flush, head_valid, bypass;

    always_comb begin
        fetch_pc_inc = fetch_pc + 32'd4;
        head_valid   = (count != '0);
`ifdef FETCH_BYPASS_EN
        bypass       = rst && (state == FETCH) && !head_valid && imem_ready && !redirect;
`else
        bypass       = 1'b0;
`endif
        imem_addr    = fetch_pc;
        imem_req     = rst && (state != FULL);
        ins_valid    = head_valid || bypass;
        ins_out      = '0;
        pc_plus4_out = '0;
        if (head_valid) begin
            ins_out      = instr_mem[rd_ptr];
            pc_plus4_out = pc4_mem[rd_ptr];
        end else if (bypass) begin
            ins_out      = imem_rdata;
            pc_plus4_out = fetch_pc_inc;
        end
    end

    // DRAIN keeps the stalled address on imem_addr and parks the redirect
    // target separately until the abandoned response arrives.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        target_next   = target;
        push          = 1'b0;
        flush         = redirect;
        pop           = head_valid && ifid_write && !redirect;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem_ready) begin
                        fetch_pc_next = redirect_pc;
                    end else begin
                        target_next = redirect_pc;
                        state_next  = DRAIN;
                    end
                end else if (imem_ready) begin
                    fetch_pc_next = fetch_pc_inc;
                    push          = !(bypass && ifid_write);
                    if (push && !pop && count == LAST) begin
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (redirect) begin
                    fetch_pc_next = redirect_pc;
                    state_next    = FETCH;
                end else if (pop) begin
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    fetch_pc_next = redirect ? redirect_pc : target;
                    state_next    = FETCH;
                end else if (redirect) begin
                    target_next = redirect_pc;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            target   <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc4_mem[i]   <= '0;
            end
        end else begin
            fetch_pc <= fetch_pc_next;
            target   <= target_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    instr_mem[wr_ptr] <= imem_rdata;
                    pc4_mem[wr_ptr]   <= fetch_pc_inc;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

endmodule
